vdp_video_out2: RTL and testbench
=================================

VDP_VIDEO_OUT2 -- requirements
Module: vdp_video_out2

Interface
REQ-001 SHALL have parameters: CW, default 8, width of each colour channel; BUF_DEPTH, default 576, line-buffer entries per bank; H_WR_START, default 0, first written h_count; H_OUT_START, default 100, first output h_count; OUT_W, default 1200, output pixels per line.
REQ-002 SHALL have ports, one per line:
clk  in  1  system clock, sole clock
reset  in  1  synchronous, active-high reset
h_count  in  11  horizontal position, 0..1367
v_count  in  10  line number; bit 0 selects the write bank
has_scanline  in  1  current output line is a scanline line
vdp_r/vdp_g/vdp_b  in  CW each  source pixel
video_r/video_g/video_b  out  CW each  scaled pixel, registered
reg_denominator  in  8  phase modulus
reg_step  in  8  phase increment per output pixel
reg_normalize  in  8  gain; result = (sum*norm)>>15
reg_scanline_level  in  2  0 off, 1 -25%, 2 -50%, 3 -75%

Function
REQ-003 SHALL write vdp_* into bank v_count[0] at address h_count-H_WR_START while H_WR_START <= h_count < H_WR_START+BUF_DEPTH.
REQ-004 SHALL read only from bank ~v_count[0], so each line outputs the previous line (ping-pong).
REQ-005 SHALL latch reg_denominator, reg_step, reg_normalize and reg_scanline_level at h_count==0; mid-line changes SHALL take effect only on the next line.
REQ-006 SHALL clear source index x and phase acc to 0 at h_count==H_OUT_START-1.
REQ-007 For each output pixel, SHALL compute acc+step; if the result is >= den, SHALL subtract den and increment x by 1, otherwise SHALL keep x; at most one increment per pixel.
REQ-008 step > den SHALL be treated as step = den; den==0 SHALL bypass interpolation (w=0, x increments every pixel).
REQ-009 Each channel SHALL be computed as out = sat(((p[x]*(den-acc) + p[x+1]*acc) * norm) >> 15), saturating to 2^CW-1, with the intermediate wide enough not to overflow (CW+8+8+1 bits).
REQ-010 When x==BUF_DEPTH-1, p[x+1] SHALL be taken as p[x] (edge clamp); x SHALL saturate at BUF_DEPTH-1 and never wrap.
REQ-011 When has_scanline=1 and level!=0, SHALL reduce the result by v>>2, v>>1 or v-(v>>2) for levels 1, 2 and 3 respectively.
REQ-012 SHALL be a 5-stage pipeline (address, RAM read, multiply, normalise/saturate, scanline): video_* for output pixel k SHALL appear exactly 5 clk after h_count==H_OUT_START+k.
REQ-013 Outside the output window, video_* SHALL be 0 with the same 5-clk alignment.
REQ-014 A simultaneous read and write to the same bank cannot occur by construction; if v_count[0] toggles mid-line, SHALL switch banks immediately without corrupting the pipeline.

Reset
REQ-015 While reset=1, video_* SHALL be 0, acc and x SHALL be 0, latched registers SHALL be 0 (bypass) and the pipeline valid flags SHALL be cleared; RAM contents need not be cleared.
REQ-016 Reset asserted mid-line SHALL force video_*=0 on the next clk; output SHALL resume at the next H_OUT_START after release.

Structure
REQ-017 Package vdp_video_out2_pkg SHALL hold the scanline-level enum, the pipeline latency constant (5) and the normalise shift constant (15).
REQ-018 Line storage SHALL be one sub-module, vdp_video_out2_line_ram: 2*BUF_DEPTH x 3*CW, one write port, one read port, 1-clk registered read.

Verification
REQ-019 den=144, step=144, norm=228, input FF/80/40 on every line -> from line 1, video = FF/80/40, first pixel at h_count H_OUT_START+5.
REQ-020 Same input as REQ-019, has_scanline=1, level=2 -> 7F/40/20; level=0 -> FF/80/40.
REQ-021 Ramp input p[i]=i, den=2, step=1, norm=0x80 (gain 1/256) -> raw interpolation sequence before gain 0,1,2,3,4...; verify post-gain values exactly against a bench model.
REQ-022 reg_step changed at mid-line -> current line unchanged; next line uses the new step.
REQ-023 Reset pulsed at h_count=600 -> video=0 from the next clk; correct output from H_OUT_START of the following line.
REQ-024 den=0 with full-scale input FF and norm=0xFF -> result saturates to FF and never wraps to a small value.

Source files
------------

// File: rtl/vdp_video_out2_pkg.sv
// Shared types and constants for the vdp_video_out2 horizontal scaler.
package vdp_video_out2_pkg;

    typedef enum logic [1:0] {
        SCAN_OFF = 2'd0,
        SCAN_25  = 2'd1,
        SCAN_50  = 2'd2,
        SCAN_75  = 2'd3
    } scan_level_e;

    localparam int PIPE_LATENCY = 5;
    localparam int NORM_SHIFT   = 15;

    typedef struct packed {
        logic       prime;
        logic       adv;
        logic [7:0] acc;
    } pix_ctl_t;

endpackage

// File: rtl/vdp_video_out2_line_ram.sv
// Two-bank line store: one write port, one read port with a registered read.
module vdp_video_out2_line_ram
    import vdp_video_out2_pkg::*;
#(
    parameter int DW    = 24,
    parameter int DEPTH = 1152,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data_q
);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

endmodule

// File: rtl/vdp_video_out2.sv
// Ping-pong line buffer with fractional horizontal interpolation, gain,
// saturation and scanline darkening in a 5-stage pipeline.
module vdp_video_out2
    import vdp_video_out2_pkg::*;
#(
    parameter int CW          = 8,
    parameter int BUF_DEPTH   = 576,
    parameter int H_WR_START  = 0,
    parameter int H_OUT_START = 100,
    parameter int OUT_W       = 1200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   h_count,
    input  logic [9:0]    v_count,
    input  logic          has_scanline,
    input  logic [CW-1:0] vdp_r,
    input  logic [CW-1:0] vdp_g,
    input  logic [CW-1:0] vdp_b,
    output logic [CW-1:0] video_r,
    output logic [CW-1:0] video_g,
    output logic [CW-1:0] video_b,
    input  logic [7:0]    reg_denominator,
    input  logic [7:0]    reg_step,
    input  logic [7:0]    reg_normalize,
    input  logic [1:0]    reg_scanline_level
);

    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int RAW = $clog2(2 * BUF_DEPTH);
    localparam int MW  = CW + 17;
    localparam int NL  = PIPE_LATENCY - 1;
    localparam logic [10:0]   WR_FIRST  = 11'(H_WR_START);
    localparam logic [10:0]   OUT_FIRST = 11'(H_OUT_START);
    localparam logic [10:0]   PRIME_H   = 11'(H_OUT_START - 1);
    localparam logic [10:0]   BUF11     = 11'(BUF_DEPTH);
    localparam logic [10:0]   OUTW11    = 11'(OUT_W);
    localparam logic [AW-1:0] X_MAX     = AW'(BUF_DEPTH - 1);
    localparam logic [MW-1:0] PIX_MAX   = MW'({CW{1'b1}});

    typedef logic [2:0][CW-1:0] pix3_t;

    logic [7:0]     den_q, den_d, step_q, step_d, norm_q, norm_d, acc_q, acc_d;
    scan_level_e    level_q, level_d;
    logic [AW-1:0]  x_q, x_d, x_nxt, rd_off;
    logic           adv_q, adv_d, act_q, act_d, in_win, inc, wr_en;
    logic [7:0]     step_eff;
    logic [8:0]     acc_sum, wl, wr;
    logic [11:0]    wr_off, out_off;
    logic [NL-1:0]  vld_q, vld_d, scan_q, scan_d;
    pix_ctl_t       s1_q, s1_d, s2_q, s2_d;
    logic [RAW-1:0] rd_addr_q, rd_addr_d, wr_addr;
    pix3_t          wr_pix, rd_pix, cur_left, left_q, left_d, rprev_q, rprev_d;
    pix3_t          sat_q, sat_d, video_q, video_d;
    logic [2:0][MW-1:0] prod_q, prod_d;
    logic [MW-1:0]  sh;
    logic           unused_vcount;

    assign unused_vcount = ^v_count[9:1];
    assign wr_pix = {vdp_r, vdp_g, vdp_b};

    // Write side, register latching at line start and the x/phase stepper.
    always_comb begin
        wr_off  = {1'b0, h_count} - {1'b0, WR_FIRST};
        wr_en   = !wr_off[11] && (wr_off[10:0] < BUF11);
        wr_addr = v_count[0] ? RAW'(BUF_DEPTH) + RAW'(wr_off[10:0]) : RAW'(wr_off[10:0]);
        out_off = {1'b0, h_count} - {1'b0, OUT_FIRST};
        in_win  = act_q && !out_off[11] && (out_off[10:0] < OUTW11);

        step_eff = (step_q > den_q) ? den_q : step_q;
        acc_sum  = {1'b0, acc_q} + {1'b0, step_eff};
        inc      = (den_q == 8'd0) || (acc_sum >= {1'b0, den_q});

        den_d   = den_q;
        step_d  = step_q;
        norm_d  = norm_q;
        level_d = level_q;
        acc_d   = acc_q;
        x_d     = x_q;
        adv_d   = adv_q;
        act_d   = act_q;
        if (h_count == 11'd0) begin
            den_d   = reg_denominator;
            step_d  = reg_step;
            norm_d  = reg_normalize;
            level_d = scan_level_e'(reg_scanline_level);
        end
        if (h_count == PRIME_H) begin
            acc_d = 8'd0;
            x_d   = '0;
            adv_d = 1'b0;
            act_d = 1'b1;
        end else if (in_win) begin
            if (den_q != 8'd0)
                acc_d = inc ? acc_q + step_eff - den_q : acc_sum[7:0];
            adv_d = inc && (x_q != X_MAX);
            if (adv_d)
                x_d = x_q + 1'b1;
        end
    end

    // Only p[x+1] is fetched per pixel; p[x] is the held left sample, reloaded
    // from the previous right sample whenever x advanced.
    always_comb begin
        s1_d.prime = (h_count == PRIME_H);
        s1_d.adv   = adv_q;
        s1_d.acc   = acc_q;
        x_nxt      = (x_q == X_MAX) ? x_q : x_q + 1'b1;
        rd_off     = s1_d.prime ? '0 : x_nxt;
        rd_addr_d  = v_count[0] ? RAW'(rd_off) : RAW'(BUF_DEPTH) + RAW'(rd_off);
        vld_d      = {vld_q[NL-2:0], in_win};
        scan_d     = {scan_q[NL-2:0], has_scanline};
        s2_d       = s1_q;

        cur_left = s2_q.adv ? rprev_q : left_q;
        left_d   = left_q;
        rprev_d  = rprev_q;
        if (s2_q.prime)
            left_d = rd_pix;
        if (vld_q[1]) begin
            left_d  = cur_left;
            rprev_d = rd_pix;
        end
        if (den_q == 8'd0) begin
            wl = 9'd256;
            wr = 9'd0;
        end else begin
            wl = {1'b0, den_q} - {1'b0, s2_q.acc};
            wr = {1'b0, s2_q.acc};
        end

        sh = '0;
        for (int c = 0; c < 3; c++) begin
            prod_d[c] = (MW'(cur_left[c]) * MW'(wl) + MW'(rd_pix[c]) * MW'(wr)) * MW'(norm_q);
            sh        = prod_q[c] >> NORM_SHIFT;
            sat_d[c]  = (sh > PIX_MAX) ? '1 : sh[CW-1:0];
            video_d[c] = '0;
            if (vld_q[NL-1]) begin
                video_d[c] = sat_q[c];
                if (scan_q[NL-1]) begin
                    case (level_q)
                        SCAN_25: video_d[c] = sat_q[c] - (sat_q[c] >> 2);
                        SCAN_50: video_d[c] = sat_q[c] >> 1;
                        SCAN_75: video_d[c] = sat_q[c] >> 2;
                        default: video_d[c] = sat_q[c];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            den_q     <= '0;
            step_q    <= '0;
            norm_q    <= '0;
            level_q   <= SCAN_OFF;
            acc_q     <= '0;
            x_q       <= '0;
            adv_q     <= 1'b0;
            act_q     <= 1'b0;
            vld_q     <= '0;
            scan_q    <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            rd_addr_q <= '0;
            left_q    <= '0;
            rprev_q   <= '0;
            prod_q    <= '0;
            sat_q     <= '0;
            video_q   <= '0;
        end else begin
            den_q     <= den_d;
            step_q    <= step_d;
            norm_q    <= norm_d;
            level_q   <= level_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            adv_q     <= adv_d;
            act_q     <= act_d;
            vld_q     <= vld_d;
            scan_q    <= scan_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            rd_addr_q <= rd_addr_d;
            left_q    <= left_d;
            rprev_q   <= rprev_d;
            prod_q    <= prod_d;
            sat_q     <= sat_d;
            video_q   <= video_d;
        end
    end

    vdp_video_out2_line_ram #(
        .DW   (3 * CW),
        .DEPTH(2 * BUF_DEPTH),
        .AW   (RAW)
    ) u_line_ram (
        .clk      (clk),
        .we       (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_pix),
        .rd_addr  (rd_addr_q),
        .rd_data_q(rd_pix)
    );

    assign video_r = video_q[2];
    assign video_g = video_q[1];
    assign video_b = video_q[0];

endmodule

// File: tb/tb_vdp_video_out2.sv
// Self-checking bench for vdp_video_out2: whole lines are driven and captured,
// then compared against a closed-form model of the scaler.
module tb_vdp_video_out2;

    localparam int BUF_DEPTH   = 576;
    localparam int H_OUT_START = 100;
    localparam int OUT_W       = 1200;
    localparam int H_TOTAL     = 1368;
    localparam int LAT         = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic       has_scanline;
    logic [7:0] vdp_r, vdp_g, vdp_b;
    logic [7:0] video_r, video_g, video_b;
    logic [7:0] reg_denominator, reg_step, reg_normalize;
    logic [1:0] reg_scanline_level;

    int checks = 0;
    int failures = 0;
    int line_no = 0;

    int mem_p [2][3][BUF_DEPTH];
    logic [7:0] cap [3][H_TOTAL];
    int ln_den, ln_step, ln_norm, ln_lvl, ln_rbank;
    bit ln_scan;

    always #5 clk = ~clk;

    vdp_video_out2 dut (
        .clk               (clk),
        .reset             (reset),
        .h_count           (h_count),
        .v_count           (v_count),
        .has_scanline      (has_scanline),
        .vdp_r             (vdp_r),
        .vdp_g             (vdp_g),
        .vdp_b             (vdp_b),
        .video_r           (video_r),
        .video_g           (video_g),
        .video_b           (video_b),
        .reg_denominator   (reg_denominator),
        .reg_step          (reg_step),
        .reg_normalize     (reg_normalize),
        .reg_scanline_level(reg_scanline_level)
    );

    function automatic int pat(int mode, int ch, int h);
        case (mode)
            0:       return (ch == 0) ? 255 : (ch == 1) ? 128 : 64;
            1:       return (ch == 0) ? (h % 256) : (ch == 1) ? ((h * 3) % 256) : 255 - (h % 256);
            3:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Output pixel k sits at source position k*step/den (step capped at den).
    function automatic int model(int ch, int k);
        int s, x, acc, xn, pl, pr, sum, v;
        s = (ln_step > ln_den) ? ln_den : ln_step;
        if (ln_den == 0) begin
            x = k;
            acc = 0;
        end else begin
            x = (k * s) / ln_den;
            acc = (k * s) % ln_den;
        end
        if (x > BUF_DEPTH - 1) x = BUF_DEPTH - 1;
        xn = (x == BUF_DEPTH - 1) ? x : x + 1;
        pl = mem_p[ln_rbank][ch][x];
        pr = mem_p[ln_rbank][ch][xn];
        sum = (ln_den == 0) ? pl * 256 : pl * (ln_den - acc) + pr * acc;
        v = (sum * ln_norm) / 32768;
        if (v > 255) v = 255;
        if (ln_scan) begin
            case (ln_lvl)
                1: v = v - v / 4;
                2: v = v / 2;
                3: v = v / 4;
                default: v = v;
            endcase
        end
        return v;
    endfunction

    task automatic run_line(input int mode, input int chg_h, input int chg_step, input int rst_h);
        int bank, p;
        bank = line_no % 2;
        for (int h = 0; h < H_TOTAL; h++) begin
            h_count = 11'(h);
            v_count = 10'(line_no);
            if (h == 0) begin
                ln_den = reg_denominator;
                ln_step = reg_step;
                ln_norm = reg_normalize;
                ln_lvl = reg_scanline_level;
                ln_scan = has_scanline;
                ln_rbank = 1 - bank;
            end
            if (h == chg_h) reg_step = 8'(chg_step);
            reset = (h == rst_h);
            for (int c = 0; c < 3; c++) begin
                p = pat(mode, c, h);
                if (h < BUF_DEPTH) mem_p[bank][c][h] = p;
                if (c == 0) vdp_r = 8'(p);
                else if (c == 1) vdp_g = 8'(p);
                else vdp_b = 8'(p);
            end
            @(negedge clk);
            cap[0][h] = video_r;
            cap[1][h] = video_g;
            cap[2][h] = video_b;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        line_no++;
    endtask

    task automatic set_regs(input int den, input int step, input int norm, input int lvl, input bit scan);
        reg_denominator = 8'(den);
        reg_step = 8'(step);
        reg_normalize = 8'(norm);
        reg_scanline_level = 2'(lvl);
        has_scanline = scan;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        h_count = 11'(H_OUT_START + 10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({video_r, video_g, video_b} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_video got=%h exp=000000", {video_r, video_g, video_b});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_flat();
        logic [7:0] exp3 [3];
        exp3[0] = 8'hFF; exp3[1] = 8'h80; exp3[2] = 8'h40;
        set_regs(144, 144, 228, 0, 1'b0);
        run_line(0, -1, 0, -1);
        run_line(0, -1, 0, -1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (cap[c][H_OUT_START + LAT] !== exp3[c]) begin
                failures++;
                $display("[TB] FAIL flat_first ch=%0d got=%h exp=%h", c, cap[c][H_OUT_START + LAT], exp3[c]);
            end
            checks++;
            if (cap[c][H_OUT_START + LAT - 1] !== 8'h00) begin
                failures++;
                $display("[TB] FAIL flat_before_window ch=%0d got=%h exp=00", c, cap[c][H_OUT_START + LAT - 1]);
            end
            checks++;
            if (cap[c][H_OUT_START + LAT + OUT_W] !== 8'h00) begin
                failures++;
                $display("[TB] FAIL flat_after_window ch=%0d got=%h exp=00", c, cap[c][H_OUT_START + LAT + OUT_W]);
            end
            for (int k = 0; k < OUT_W; k++) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== 8'(model(c, k))) begin
                    failures++;
                    $display("[TB] FAIL flat_px k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], 8'(model(c, k)));
                end
            end
        end
    endtask

    task automatic test_scanline();
        logic [7:0] exp_half [3];
        logic [7:0] exp_full [3];
        exp_half[0] = 8'h7F; exp_half[1] = 8'h40; exp_half[2] = 8'h20;
        exp_full[0] = 8'hFF; exp_full[1] = 8'h80; exp_full[2] = 8'h40;
        set_regs(144, 144, 228, 2, 1'b1);
        run_line(0, -1, 0, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k += 7) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== exp_half[c]) begin
                    failures++;
                    $display("[TB] FAIL scan_lvl2 k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], exp_half[c]);
                end
            end
        set_regs(144, 144, 228, 0, 1'b1);
        run_line(0, -1, 0, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k += 7) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== exp_full[c]) begin
                    failures++;
                    $display("[TB] FAIL scan_lvl0 k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], exp_full[c]);
                end
            end
    endtask

    task automatic test_ramp();
        set_regs(2, 1, 8'h80, 0, 1'b0);
        run_line(1, -1, 0, -1);
        run_line(1, -1, 0, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k++) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== 8'(model(c, k))) begin
                    failures++;
                    $display("[TB] FAIL ramp_px k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], 8'(model(c, k)));
                end
            end
    endtask

    task automatic test_step_change();
        set_regs(7, 3, 200, 0, 1'b0);
        run_line(2, -1, 0, -1);
        run_line(2, 600, 5, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k++) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== 8'(model(c, k))) begin
                    failures++;
                    $display("[TB] FAIL step_old_line k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], 8'(model(c, k)));
                end
            end
        run_line(2, -1, 0, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k++) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== 8'(model(c, k))) begin
                    failures++;
                    $display("[TB] FAIL step_new_line k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], 8'(model(c, k)));
                end
            end
    endtask

    task automatic test_reset_midline();
        set_regs(144, 144, 228, 0, 1'b0);
        run_line(2, -1, 0, 600);
        for (int c = 0; c < 3; c++)
            for (int h = 601; h < H_TOTAL; h++) begin
                checks++;
                if (cap[c][h] !== 8'h00) begin
                    failures++;
                    $display("[TB] FAIL rst_mid_zero h=%0d ch=%0d got=%h exp=00", h, c, cap[c][h]);
                end
            end
        run_line(2, -1, 0, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k++) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== 8'(model(c, k))) begin
                    failures++;
                    $display("[TB] FAIL rst_mid_resume k=%0d ch=%0d got=%h exp=%h", k, c, cap[c][H_OUT_START + LAT + k], 8'(model(c, k)));
                end
            end
    endtask

    task automatic test_saturate();
        set_regs(0, 0, 255, 0, 1'b0);
        run_line(3, -1, 0, -1);
        run_line(3, -1, 0, -1);
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < OUT_W; k++) begin
                checks++;
                if (cap[c][H_OUT_START + LAT + k] !== 8'hFF) begin
                    failures++;
                    $display("[TB] FAIL sat_px k=%0d ch=%0d got=%h exp=ff", k, c, cap[c][H_OUT_START + LAT + k]);
                end
            end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            set_regs(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            run_line(2, -1, 0, -1);
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < OUT_W; k++) begin
                    checks++;
                    if (cap[c][H_OUT_START + LAT + k] !== 8'(model(c, k))) begin
                        failures++;
                        $display("[TB] FAIL rand_px line=%0d k=%0d ch=%0d got=%h exp=%h den=%0d step=%0d",
                                 n, k, c, cap[c][H_OUT_START + LAT + k], 8'(model(c, k)), ln_den, ln_step);
                    end
                end
        end
    endtask

    initial begin
        reset = 1'b1;
        h_count = '0;
        v_count = '0;
        vdp_r = '0;
        vdp_g = '0;
        vdp_b = '0;
        set_regs(0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_flat();
        test_scanline();
        test_ramp();
        test_step_change();
        test_reset_midline();
        test_saturate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
